// File: rtl/debug_run_ctrl.sv
// ---------------------------------------------------------------------------
// DebugRunCtrl (module debug_run_ctrl)
//
// Purpose:
//   Debug-unit sequencer sitting between the UART receiver and the MIPS
//   pipeline. Host command bytes select what happens next:
//     'L' loads a program (4 bytes per word, MSB first) into instruction
//         memory until the HALT word has been written,
//     'C' runs the pipeline continuously until it retires HALT,
//     'S' enters single-step mode, after which every 'N' executes one step.
//   At every stop point a dump of the machine state is requested from the
//   TX interface, and the sequencer waits for it to complete.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_rx_data     received UART byte, valid when i_rx_done is high
//   i_rx_done     one-cycle strobe per received byte
//   i_halt        pipeline has retired HALT (level)
//   i_dump_done   TX interface finished sending the dump (pulse)
//   o_imem_we     instruction memory write strobe
//   o_imem_addr   instruction memory word address
//   o_imem_data   instruction word to write
//   o_cpu_reset   holds the pipeline in reset
//   o_cpu_valid   pipeline advance enable (continuous mode)
//   o_exec_mode   0 = continuous, 1 = step
//   o_step        one-cycle step pulse
//   o_dump_start  one-cycle dump request to the TX interface
//   o_done        program finished and final dump sent
//   o_error       sticky: a load filled imem without seeing the HALT word
// ---------------------------------------------------------------------------
module debug_run_ctrl #(
    parameter int          IMEM_AW   = 8,
    parameter logic [31:0] HALT_WORD = 32'hFC000000,
    parameter logic [7:0]  CMD_LOAD  = 8'h4C,
    parameter logic [7:0]  CMD_CONT  = 8'h43,
    parameter logic [7:0]  CMD_STEP  = 8'h53,
    parameter logic [7:0]  CMD_NEXT  = 8'h4E
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_halt,
    input  logic               i_dump_done,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [31:0]        o_imem_data,
    output logic               o_cpu_reset,
    output logic               o_cpu_valid,
    output logic               o_exec_mode,
    output logic               o_step,
    output logic               o_dump_start,
    output logic               o_done,
    output logic               o_error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        RUN,
        STEP_WAIT,
        DUMP,
        FINISH
    } state_t;

    localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;
    localparam logic [IMEM_AW-1:0] ADDR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         byteCnt_q, byteCnt_d;
    logic               we_q, we_d;
    logic               mode_q, mode_d;
    logic               step_q, step_d;
    logic               dumpStart_q, dumpStart_d;
    logic               error_q, error_d;

    // State register. Reset aborts any load or dump in progress and throws
    // away a partially assembled word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            word_q      <= '0;
            byteCnt_q   <= '0;
            we_q        <= 1'b0;
            mode_q      <= 1'b0;
            step_q      <= 1'b0;
            dumpStart_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            byteCnt_q   <= byteCnt_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            dumpStart_q <= dumpStart_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic. Strobes (write, step, dump request) default low so
    // that each is a single-cycle pulse registered on the cycle after the
    // event that caused it. Bytes not meaningful in the current state are
    // simply not looked at, which drops them.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        byteCnt_d   = byteCnt_q;
        we_d        = 1'b0;
        mode_d      = mode_q;
        step_d      = 1'b0;
        dumpStart_d = 1'b0;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                if (i_rx_done && i_rx_data == CMD_LOAD) begin
                    state_d   = LOAD;
                    addr_d    = '0;
                    byteCnt_d = '0;
                    error_d   = 1'b0;
                end
            end

            LOAD: begin
                // The write strobe cycle decides what follows the word:
                // the HALT word ends the load, a full memory without it is
                // an error, otherwise move on to the next address.
                if (we_q) begin
                    if (word_q == HALT_WORD) begin
                        state_d = READY;
                        if (addr_q != ADDR_MAX) begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end else if (addr_q == ADDR_MAX) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                // Bytes are only assembled while we are staying in LOAD.
                if (i_rx_done && state_d == LOAD) begin
                    word_d    = {word_q[23:0], i_rx_data};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        we_d = 1'b1;
                    end
                end
            end

            READY: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_CONT) begin
                        state_d = RUN;
                        mode_d  = 1'b0;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_d = STEP_WAIT;
                        mode_d  = 1'b1;
                    end else if (i_rx_data == CMD_LOAD) begin
                        state_d   = LOAD;
                        addr_d    = '0;
                        byteCnt_d = '0;
                        error_d   = 1'b0;
                    end
                end
            end

            RUN: begin
                if (i_halt) begin
                    state_d     = DUMP;
                    dumpStart_d = 1'b1;
                end
            end

            STEP_WAIT: begin
                // A retired HALT takes priority over a pending step command:
                // the machine is finished, so only the final dump happens.
                if (i_halt) begin
                    state_d     = DUMP;
                    dumpStart_d = 1'b1;
                end else if (i_rx_done && i_rx_data == CMD_NEXT) begin
                    state_d     = DUMP;
                    dumpStart_d = 1'b1;
                    step_d      = 1'b1;
                end
            end

            DUMP: begin
                // Continuous mode only gets here through HALT, so anything
                // other than step mode without HALT is the final dump.
                if (i_dump_done) begin
                    if (i_halt || !mode_q) begin
                        state_d = FINISH;
                    end else begin
                        state_d = STEP_WAIT;
                    end
                end
            end

            FINISH: begin
                if (i_rx_done && i_rx_data == CMD_LOAD) begin
                    state_d   = LOAD;
                    addr_d    = '0;
                    byteCnt_d = '0;
                    error_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The advance enable drops in the same cycle HALT is seen
    // so the pipeline never moves past the halting instruction.
    always_comb begin
        o_imem_we    = we_q;
        o_imem_addr  = addr_q;
        o_imem_data  = word_q;
        o_cpu_reset  = (state_q == IDLE) || (state_q == LOAD);
        o_cpu_valid  = (state_q == RUN) && !i_halt;
        o_exec_mode  = mode_q;
        o_step       = step_q;
        o_dump_start = dumpStart_q;
        o_done       = (state_q == FINISH);
        o_error      = error_q;
    end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for debug_run_ctrl. Two instances share the same stimulus: one
// with the default 256-word memory and one with a 4-word memory so that the
// load-overflow path is reachable quickly.
// ---------------------------------------------------------------------------
module tb_debug_run_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  rxData;
    logic        rxDone;
    logic        halt;
    logic        dumpDone;

    logic        bWe, bCpuReset, bValid, bMode, bStep, bDumpStart, bDone, bError;
    logic [7:0]  bAddr;
    logic [31:0] bData;

    logic        sWe, sCpuReset, sValid, sMode, sStep, sDumpStart, sDone, sError;
    logic [1:0]  sAddr;
    logic [31:0] sData;

    int checks;
    int passed;
    int stepCount;
    int dumpCount;
    int smallWeCount;
    int overlapCount;

    typedef struct {
        logic        rxDone;
        logic [7:0]  rxData;
        logic        halt;
        logic        dumpDone;
        logic        expWe;
        logic [7:0]  expAddr;
        logic [31:0] expData;
        logic        expCpuReset;
        logic [3:0]  expFlags;
    } vec_t;

    vec_t vecs[13];

    debug_run_ctrl dutBig (
        .i_clk(clk), .i_reset(reset), .i_rx_data(rxData), .i_rx_done(rxDone),
        .i_halt(halt), .i_dump_done(dumpDone),
        .o_imem_we(bWe), .o_imem_addr(bAddr), .o_imem_data(bData),
        .o_cpu_reset(bCpuReset), .o_cpu_valid(bValid), .o_exec_mode(bMode),
        .o_step(bStep), .o_dump_start(bDumpStart), .o_done(bDone),
        .o_error(bError)
    );

    debug_run_ctrl #(.IMEM_AW(2)) dutSmall (
        .i_clk(clk), .i_reset(reset), .i_rx_data(rxData), .i_rx_done(rxDone),
        .i_halt(halt), .i_dump_done(dumpDone),
        .o_imem_we(sWe), .o_imem_addr(sAddr), .o_imem_data(sData),
        .o_cpu_reset(sCpuReset), .o_cpu_valid(sValid), .o_exec_mode(sMode),
        .o_step(sStep), .o_dump_start(sDumpStart), .o_done(sDone),
        .o_error(sError)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bStep) stepCount <= stepCount + 1;
        if (bDumpStart) dumpCount <= dumpCount + 1;
        if (sWe) smallWeCount <= smallWeCount + 1;
        if (bStep && bValid) overlapCount <= overlapCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rxDone   = v.rxDone;
        rxData   = v.rxData;
        halt     = v.halt;
        dumpDone = v.dumpDone;
        tick();
        rxDone   = 1'b0;
        dumpDone = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxData = b;
        rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
    endtask

    // Sends one word MSB first and checks the resulting write strobe on the
    // large instance, then lets the write cycle complete.
    task automatic loadWord(input logic [31:0] w, input logic [7:0] expAddr);
        for (int b = 0; b < 4; b++) begin
            sendByte(w[31-8*b -: 8]);
        end
        checkOutput($sformatf("write we @%0d", expAddr), {31'd0, bWe}, 32'd1);
        checkOutput($sformatf("write addr @%0d", expAddr), {24'd0, bAddr}, {24'd0, expAddr});
        checkOutput($sformatf("write data @%0d", expAddr), bData, w);
        tick();
    endtask

    task automatic loadProgram();
        sendByte(8'h4C);
        loadWord(32'h00000001, 8'd0);
        loadWord(32'hFC000000, 8'd1);
        checkOutput("ready cpu_reset", {31'd0, bCpuReset}, 32'd0);
    endtask

    initial begin
        int validCount;
        int stepBase;
        int dumpBase;
        int weBase;

        checks = 0;
        passed = 0;
        stepCount = 0;
        dumpCount = 0;
        smallWeCount = 0;
        overlapCount = 0;
        rxData = 8'h00;
        rxDone = 1'b0;
        halt = 1'b0;
        dumpDone = 1'b0;
        reset = 1'b0;

        // Flags are {valid, step, dump_start, done}.
        vecs[0]  = '{1'b1, 8'h4C, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00000000, 1'b1, 4'b0000};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00000000, 1'b1, 4'b0000};
        vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00000000, 1'b1, 4'b0000};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 32'h00000000, 1'b1, 4'b0000};
        vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'd0, 32'h00000001, 1'b1, 4'b0000};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 32'h00000001, 1'b1, 4'b0000};
        vecs[6]  = '{1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 8'd1, 32'h000001FC, 1'b1, 4'b0000};
        vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 32'h0001FC00, 1'b1, 4'b0000};
        vecs[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 32'h01FC0000, 1'b1, 4'b0000};
        vecs[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1, 32'hFC000000, 1'b1, 4'b0000};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2, 32'hFC000000, 1'b0, 4'b0000};
        vecs[11] = '{1'b1, 8'h4E, 1'b0, 1'b0, 1'b0, 8'd2, 32'hFC000000, 1'b0, 4'b0000};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd2, 32'hFC000000, 1'b0, 4'b0000};

        applyReset();
        checkOutput("reset we/addr/data", {bWe, bAddr, bData[22:0]}, 32'd0);
        checkOutput("reset cpu_reset", {31'd0, bCpuReset}, 32'd1);
        checkOutput("reset flags", {26'd0, bValid, bMode, bStep, bDumpStart, bDone, bError}, 32'd0);

        // Program load, then ignored bytes/dump_done in READY.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d we", i), {31'd0, bWe}, {31'd0, vecs[i].expWe});
            checkOutput($sformatf("vec%0d addr", i), {24'd0, bAddr}, {24'd0, vecs[i].expAddr});
            checkOutput($sformatf("vec%0d data", i), bData, vecs[i].expData);
            checkOutput($sformatf("vec%0d cpu_reset", i), {31'd0, bCpuReset}, {31'd0, vecs[i].expCpuReset});
            checkOutput($sformatf("vec%0d flags", i), {28'd0, bValid, bStep, bDumpStart, bDone},
                        {28'd0, vecs[i].expFlags});
        end

        // Continuous run for 20 cycles; a stray 'S' during RUN is dropped.
        dumpBase = dumpCount;
        sendByte(8'h43);
        validCount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bValid) validCount++;
            if (i == 7) begin
                rxData = 8'h53;
                rxDone = 1'b1;
            end
            tick();
            rxDone = 1'b0;
        end
        checkOutput("run mode stays continuous", {31'd0, bMode}, 32'd0);
        halt = 1'b1;
        #1;
        checkOutput("valid drops with halt", {31'd0, bValid}, 32'd0);
        tick();
        checkOutput("run dump_start", {31'd0, bDumpStart}, 32'd1);
        sendByte(8'h4C);
        checkOutput("byte in DUMP ignored", {bDumpStart, bCpuReset, bDone}, 32'd0);
        tick();
        dumpDone = 1'b1;
        tick();
        dumpDone = 1'b0;
        checkOutput("run done", {31'd0, bDone}, 32'd1);
        checkOutput("run valid cycles", validCount, 32'd20);
        checkOutput("run dump count", dumpCount - dumpBase, 32'd1);

        // Single-step: three steps, HALT appears during the third dump.
        halt = 1'b0;
        loadProgram();
        stepBase = stepCount;
        dumpBase = dumpCount;
        sendByte(8'h53);
        checkOutput("step mode", {31'd0, bMode}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            sendByte(8'h4E);
            checkOutput($sformatf("step%0d pulse", k), {bStep, bDumpStart}, 32'd3);
            tick();
            checkOutput($sformatf("step%0d pulse ends", k), {bStep, bDumpStart}, 32'd0);
            if (k == 2) halt = 1'b1;
            dumpDone = 1'b1;
            tick();
            dumpDone = 1'b0;
            checkOutput($sformatf("step%0d done", k), {31'd0, bDone}, (k == 2) ? 32'd1 : 32'd0);
        end
        checkOutput("step pulse count", stepCount - stepBase, 32'd3);
        checkOutput("step dump count", dumpCount - dumpBase, 32'd3);

        // HALT and 'N' together in STEP_WAIT: final dump, no step pulse.
        halt = 1'b0;
        loadProgram();
        sendByte(8'h53);
        halt = 1'b1;
        sendByte(8'h4E);
        checkOutput("halt beats next", {bStep, bDumpStart}, 32'd1);
        dumpDone = 1'b1;
        tick();
        dumpDone = 1'b0;
        checkOutput("halt beats next done", {31'd0, bDone}, 32'd1);
        halt = 1'b0;

        // Overflow on the 4-word instance.
        applyReset();
        weBase = smallWeCount;
        sendByte(8'h4C);
        for (int w = 0; w < 4; w++) begin
            loadWord(32'h11111111 * (w + 1), w[7:0]);
        end
        checkOutput("overflow error", {31'd0, sError}, 32'd1);
        checkOutput("overflow back to idle", {31'd0, sCpuReset}, 32'd1);
        tick();
        checkOutput("overflow write count", smallWeCount - weBase, 32'd4);
        checkOutput("big instance no error", {31'd0, bError}, 32'd0);
        sendByte(8'h4C);
        checkOutput("load clears error", {31'd0, sError}, 32'd0);

        // Reset in the middle of a word, then a clean reload.
        sendByte(8'hAB);
        sendByte(8'hCD);
        applyReset();
        checkOutput("abort addr/data", {bWe, bAddr, bData[22:0]}, 32'd0);
        checkOutput("abort cpu_reset", {31'd0, bCpuReset}, 32'd1);
        sendByte(8'h4C);
        loadWord(32'h12345678, 8'd0);

        checkOutput("step/valid never together", overlapCount, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
